// File: rtl/mvm_ctrl_v2.sv
// Read-sequencing controller for the matrix-vector engine: walks vector/matrix
// buffers row by row and delays the accumulator sideband to match read latency.
module mvm_ctrl_v2 #(
    parameter int VEC_ADDRW = 8,
    parameter int MAT_ADDRW = 9,
    parameter int VEC_SIZEW = VEC_ADDRW + 1,
    parameter int MAT_SIZEW = MAT_ADDRW + 1,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 stall,
    input  logic [VEC_ADDRW-1:0] vec_start_addr,
    input  logic [VEC_SIZEW-1:0] vec_num_words,
    input  logic [MAT_ADDRW-1:0] mat_start_addr,
    input  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
    input  logic [MAT_SIZEW-1:0] mat_row_stride,
    output logic [VEC_ADDRW-1:0] vec_raddr,
    output logic [MAT_ADDRW-1:0] mat_raddr,
    output logic                 accum_first,
    output logic                 accum_last,
    output logic                 ovalid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [VEC_ADDRW-1:0] vec_base_q, vec_base_d;
    logic [VEC_SIZEW-1:0] num_words_q, num_words_d;
    logic [MAT_SIZEW-1:0] num_rows_q, num_rows_d;
    logic [MAT_ADDRW-1:0] stride_q, stride_d;
    logic [VEC_SIZEW-1:0] word_q, word_d;
    logic [MAT_SIZEW-1:0] row_q, row_d;
    logic [MAT_ADDRW-1:0] row_base_q, row_base_d;
    logic [VEC_ADDRW-1:0] vec_raddr_q, vec_raddr_d;
    logic [MAT_ADDRW-1:0] mat_raddr_q, mat_raddr_d;

    logic iss_valid;
    logic iss_first;
    logic iss_last;
    logic job_end;
    logic pend;
    logic done_s;

    assign iss_valid = (state_q == ST_RUN) && !abort && !stall;
    assign iss_first = (word_q == '0);
    assign iss_last  = (word_q == num_words_q - VEC_SIZEW'(1));
    assign job_end   = iss_last && (row_q == num_rows_q - MAT_SIZEW'(1));

    // Job FSM, descriptor latch and address walk; addresses are kept as running
    // sums so row*stride never needs a multiplier.
    always_comb begin
        state_d     = state_q;
        vec_base_d  = vec_base_q;
        num_words_d = num_words_q;
        num_rows_d  = num_rows_q;
        stride_d    = stride_q;
        word_d      = word_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        vec_raddr_d = vec_raddr_q;
        mat_raddr_d = mat_raddr_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    vec_base_d  = vec_start_addr;
                    num_words_d = vec_num_words;
                    num_rows_d  = mat_num_rows_per_olane;
                    stride_d    = mat_row_stride[MAT_ADDRW-1:0];
                    word_d      = '0;
                    row_d       = '0;
                    row_base_d  = mat_start_addr;
                    vec_raddr_d = vec_start_addr;
                    mat_raddr_d = mat_start_addr;
                    if ((vec_num_words != '0) && (mat_num_rows_per_olane != '0)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!stall) begin
                    if (iss_last) begin
                        word_d      = '0;
                        row_d       = row_q + MAT_SIZEW'(1);
                        row_base_d  = row_base_q + stride_q;
                        vec_raddr_d = vec_base_q;
                        mat_raddr_d = row_base_q + stride_q;
                    end else begin
                        word_d      = word_q + VEC_SIZEW'(1);
                        vec_raddr_d = vec_raddr_q + VEC_ADDRW'(1);
                        mat_raddr_d = mat_raddr_q + MAT_ADDRW'(1);
                    end
                    if (job_end) begin
                        state_d = (RD_LAT == 0) ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (abort || !pend) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completion pulse lines up with the final beat leaving the sideband pipe.
    always_comb begin
        done_s = 1'b0;
        if (state_q == ST_DRAIN) begin
            done_s = !abort && !pend;
        end else if (state_q == ST_RUN) begin
            done_s = (RD_LAT == 0) && iss_valid && job_end;
        end else begin
            done_s = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_base_q  <= '0;
            num_words_q <= '0;
            num_rows_q  <= '0;
            stride_q    <= '0;
            word_q      <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            vec_raddr_q <= '0;
            mat_raddr_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_base_q  <= vec_base_d;
            num_words_q <= num_words_d;
            num_rows_q  <= num_rows_d;
            stride_q    <= stride_d;
            word_q      <= word_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            vec_raddr_q <= vec_raddr_d;
            mat_raddr_q <= mat_raddr_d;
        end
    end

    generate
        if (RD_LAT > 0) begin : g_pipe
            logic [RD_LAT-1:0] pv_q, pv_d;
            logic [RD_LAT-1:0] pf_q, pf_d;
            logic [RD_LAT-1:0] pl_q, pl_d;

            // Sideband shift register; stalls enter as bubbles, abort flushes it.
            always_comb begin
                pv_d    = '0;
                pf_d    = '0;
                pl_d    = '0;
                pend    = 1'b0;
                if (!abort) begin
                    pv_d[0] = iss_valid;
                    pf_d[0] = iss_valid && iss_first;
                    pl_d[0] = iss_valid && iss_last;
                    for (int i = 1; i < RD_LAT; i++) begin
                        pv_d[i] = pv_q[i-1];
                        pf_d[i] = pf_q[i-1];
                        pl_d[i] = pl_q[i-1];
                    end
                end else begin
                    pv_d = '0;
                end
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    pend = pend | pv_q[i];
                end
            end

            // Sideband pipeline registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_q <= '0;
                    pf_q <= '0;
                    pl_q <= '0;
                end else begin
                    pv_q <= pv_d;
                    pf_q <= pf_d;
                    pl_q <= pl_d;
                end
            end

            assign ovalid      = pv_q[RD_LAT-1];
            assign accum_first = pf_q[RD_LAT-1];
            assign accum_last  = pl_q[RD_LAT-1];
        end else begin : g_nopipe
            assign pend        = 1'b0;
            assign ovalid      = iss_valid;
            assign accum_first = iss_valid && iss_first;
            assign accum_last  = iss_valid && iss_last;
        end
    endgenerate

    assign vec_raddr = vec_raddr_q;
    assign mat_raddr = mat_raddr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_s;

endmodule

// File: tb/tb_mvm_ctrl_v2.sv
// Randomised bench for mvm_ctrl_v2: three instances (RD_LAT 0, 1, 3) share one
// stimulus stream and are compared cycle by cycle against a beat-schedule model.
module tb_mvm_ctrl_v2;

    localparam int VA = 8;
    localparam int MA = 9;
    localparam int VS = VA + 1;
    localparam int MS = MA + 1;
    localparam int NL = 3;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          rst, start, abort, stall;
    logic [VA-1:0] vec_start_addr;
    logic [VS-1:0] vec_num_words;
    logic [MA-1:0] mat_start_addr;
    logic [MS-1:0] mat_num_rows_per_olane;
    logic [MS-1:0] mat_row_stride;

    logic [VA-1:0] vec_raddr   [NL];
    logic [MA-1:0] mat_raddr   [NL];
    logic          accum_first [NL];
    logic          accum_last  [NL];
    logic          ovalid      [NL];
    logic          busy        [NL];
    logic          done        [NL];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NL; g++) begin : g_dut
            mvm_ctrl_v2 #(
                .VEC_ADDRW(VA),
                .MAT_ADDRW(MA),
                .RD_LAT   ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
            ) u_dut (
                .clk                   (clk),
                .rst                   (rst),
                .start                 (start),
                .abort                 (abort),
                .stall                 (stall),
                .vec_start_addr        (vec_start_addr),
                .vec_num_words         (vec_num_words),
                .mat_start_addr        (mat_start_addr),
                .mat_num_rows_per_olane(mat_num_rows_per_olane),
                .mat_row_stride        (mat_row_stride),
                .vec_raddr             (vec_raddr[g]),
                .mat_raddr             (mat_raddr[g]),
                .accum_first           (accum_first[g]),
                .accum_last            (accum_last[g]),
                .ovalid                (ovalid[g]),
                .busy                  (busy[g]),
                .done                  (done[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;

    bit stall_sch [256];
    int abort_beat;
    bit do_glitch;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_sched();
        for (int j = 0; j < 256; j++) stall_sch[j] = 1'b0;
        abort_beat = -1;
        do_glitch  = 1'b0;
    endtask

    task automatic randomize_desc();
        vec_start_addr         = VA'($urandom);
        vec_num_words          = VS'($urandom);
        mat_start_addr         = MA'($urandom);
        mat_num_rows_per_olane = MS'($urandom);
        mat_row_stride         = MS'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < NL; g++) begin
            chk($sformatf("%s L%0d vec_raddr", tag, lat_of(g)), 32'(vec_raddr[g]), 32'd0);
            chk($sformatf("%s L%0d mat_raddr", tag, lat_of(g)), 32'(mat_raddr[g]), 32'd0);
            chk($sformatf("%s L%0d first", tag, lat_of(g)), 32'(accum_first[g]), 32'd0);
            chk($sformatf("%s L%0d last", tag, lat_of(g)), 32'(accum_last[g]), 32'd0);
            chk($sformatf("%s L%0d ovalid", tag, lat_of(g)), 32'(ovalid[g]), 32'd0);
            chk($sformatf("%s L%0d busy", tag, lat_of(g)), 32'(busy[g]), 32'd0);
            chk($sformatf("%s L%0d done", tag, lat_of(g)), 32'(done[g]), 32'd0);
        end
    endtask

    // Called #1 after a rising edge with every instance idle; returns the same way.
    task automatic run_job(input int vs, input int w, input int ms, input int r, input int s);
        int  n, a, last_c, end_j, gl, kc, kk, lat;
        int  ic[$];
        bit  aborted, in_run;
        bit  e_busy, e_done, e_ov;
        n = w * r;
        for (int j = 0; (ic.size() < n) && (j < 256); j++) begin
            if (!stall_sch[j]) ic.push_back(j);
        end
        last_c  = (n > 0) ? ic[n-1] : 0;
        aborted = (abort_beat >= 0) && (abort_beat < n);
        a       = aborted ? ic[abort_beat] : BIG;
        end_j   = (n == 0) ? 1 : (aborted ? a + 1 : last_c + 4);
        gl      = (do_glitch && n > 0) ? int'($urandom_range(0, aborted ? a : last_c)) : -1;

        vec_start_addr         = VA'(vs);
        vec_num_words          = VS'(w);
        mat_start_addr         = MA'(ms);
        mat_num_rows_per_olane = MS'(r);
        mat_row_stride         = MS'(s);
        start = 1'b1;
        abort = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NL; g++) begin
            chk($sformatf("pre L%0d busy", lat_of(g)), 32'(busy[g]), 32'd0);
            chk($sformatf("pre L%0d ovalid", lat_of(g)), 32'(ovalid[g]), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < end_j; j++) begin
            stall = stall_sch[j];
            abort = (j == a);
            start = (j == gl);
            randomize_desc();
            @(negedge clk);
            kc = 0;
            foreach (ic[k]) if (ic[k] < j) kc++;
            in_run = (n > 0) && (j <= last_c) && (j <= a);
            for (int g = 0; g < NL; g++) begin
                lat    = lat_of(g);
                e_busy = (n == 0) ? (j == 0) : (aborted ? (j <= a) : (j <= last_c + lat));
                e_done = (n == 0) ? (j == 0) : (!aborted && (j == last_c + lat));
                kk     = -1;
                foreach (ic[k]) begin
                    if ((ic[k] + lat == j) && (ic[k] < a) && (j <= a)) kk = k;
                end
                e_ov = (kk >= 0);
                chk($sformatf("L%0d j%0d busy", lat, j), 32'(busy[g]), 32'(e_busy));
                chk($sformatf("L%0d j%0d done", lat, j), 32'(done[g]), 32'(e_done));
                chk($sformatf("L%0d j%0d ovalid", lat, j), 32'(ovalid[g]), 32'(e_ov));
                if (e_ov) begin
                    chk($sformatf("L%0d j%0d first", lat, j), 32'(accum_first[g]), 32'((kk % w) == 0));
                    chk($sformatf("L%0d j%0d last", lat, j), 32'(accum_last[g]), 32'((kk % w) == w - 1));
                end
                if (in_run) begin
                    chk($sformatf("L%0d j%0d vec_raddr", lat, j), 32'(vec_raddr[g]),
                        32'((vs + kc % w) % 256));
                    chk($sformatf("L%0d j%0d mat_raddr", lat, j), 32'(mat_raddr[g]),
                        32'((ms + (kc / w) * s + kc % w) % 512));
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        vec_start_addr         = '0;
        vec_num_words          = '0;
        mat_start_addr         = '0;
        mat_num_rows_per_olane = '0;
        mat_row_stride         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;

        // Directed cases from the test plan
        clear_sched();
        run_job(3, 4, 5, 2, 4);
        clear_sched();
        run_job(3, 2, 510, 2, 10);
        clear_sched();
        run_job(17, 1, 100, 3, 7);
        clear_sched();
        stall_sch[1] = 1'b1;
        stall_sch[2] = 1'b1;
        run_job(0, 3, 0, 1, 0);
        clear_sched();
        abort_beat = 5;
        run_job(9, 4, 40, 4, 4);
        clear_sched();
        run_job(3, 4, 5, 2, 4);
        clear_sched();
        run_job(1, 0, 2, 3, 5);
        clear_sched();
        run_job(1, 3, 2, 0, 5);
        clear_sched();
        do_glitch = 1'b1;
        run_job(3, 4, 5, 2, 4);

        // Reset mid-job: nothing resumes afterwards
        vec_start_addr         = VA'(20);
        vec_num_words          = VS'(4);
        mat_start_addr         = MA'(30);
        mat_num_rows_per_olane = MS'(3);
        mat_row_stride         = MS'(6);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_sweep");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            for (int g = 0; g < NL; g++) begin
                chk($sformatf("post_rst c%0d L%0d busy", c, lat_of(g)), 32'(busy[g]), 32'd0);
                chk($sformatf("post_rst c%0d L%0d ovalid", c, lat_of(g)), 32'(ovalid[g]), 32'd0);
            end
        end
        @(posedge clk);
        #1;

        // Randomised jobs with stalls, aborts and stray start pulses
        for (int t = 0; t < 40; t++) begin
            clear_sched();
            for (int j = 0; j < 128; j++) stall_sch[j] = ($urandom_range(0, 3) == 0);
            abort_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 19)) : -1;
            do_glitch  = ($urandom_range(0, 3) == 0);
            run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 511)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 1023)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mvm_ctrl_v2.md
# mvm_ctrl_v2

Second-generation read-sequencing controller for the matrix-vector multiplication engine. On `start` it latches a job descriptor and walks the vector and matrix buffers row by row, word by word, issuing one vector address and one matrix address per beat. Unlike the first-generation controller it supports a programmable matrix row stride, issue-side stall, job abort, and a parametrised memory read latency. The accumulator sideband (`accum_first`, `accum_last`, `ovalid`) is delayed to line up with returned read data.

## Interface
- `VEC_ADDRW`, 8, vector buffer address width
- `MAT_ADDRW`, 9, matrix buffer address width
- `VEC_SIZEW`, `VEC_ADDRW+1`, width of the word-count field
- `MAT_SIZEW`, `MAT_ADDRW+1`, width of the row-count and stride fields
- `RD_LAT`, 1, buffer read latency in cycles; range 0..4; 0 means sideband is aligned with addresses
- `clk` in 1: clock. One clock domain; all logic on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: job request; sampled only in IDLE
- `abort` in 1: cancel the current job; sampled every cycle
- `stall` in 1: issue throttle; no beat is issued in a cycle where it is high
- `vec_start_addr` in VEC_ADDRW: first vector word
- `vec_num_words` in VEC_SIZEW: words per row (W)
- `mat_start_addr` in MAT_ADDRW: first matrix word
- `mat_num_rows_per_olane` in MAT_SIZEW: rows (R)
- `mat_row_stride` in MAT_SIZEW: address distance between row starts (S)
- `vec_raddr` out VEC_ADDRW: vector read address
- `mat_raddr` out MAT_ADDRW: matrix read address
- `accum_first` out 1: beat is word 0 of a row (data-aligned)
- `accum_last` out 1: beat is word W-1 of a row (data-aligned)
- `ovalid` out 1: beat data valid at the accumulator
- `busy` out 1: job in progress
- `done` out 1: one-cycle pulse on normal job completion

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `start=1 && abort=0`: latch all descriptor inputs and reset the row/word counters to 0.
  - Next state is RUN if W≠0 and R≠0, otherwise DRAIN.
  - The descriptor inputs are don't-care after this start cycle.
- **RUN:**
  - A beat issues in every cycle with `stall=0`.
  - Issued beat: `vec_raddr = vec_start + word`, `mat_raddr = mat_start + row*S + word`.
  - Arithmetic is modulo 2^VEC_ADDRW and 2^MAT_ADDRW respectively (wrap, no error).
  - `row*S` is computed incrementally: a row-base register advances by S at each row end. No multiplier.
  - After each issued beat, the word counter increments. At W-1 it wraps to 0 and the row counter increments.
  - Issuing beat (R-1, W-1) moves the FSM to DRAIN.
  - In stall cycles the address outputs hold and no beat enters the sideband pipeline.
- **DRAIN:** wait until the sideband pipeline is empty, then go to IDLE. `done` pulses in the last DRAIN cycle.
- **Sideband pipeline:**
  - `RD_LAT`-deep shift register carrying {valid, first, last}. It shifts every cycle; stall does not freeze it, it inserts bubbles.
  - With `RD_LAT=0` the sideband is combinationally tied to the issue stage.
  - When W=1, every beat has `first=last=1`.
- **Abort:**
  - In RUN or DRAIN: no further issue, pipeline flushed (`ovalid` forced 0 from the next cycle), IDLE next cycle.
  - `done` is not pulsed.
  - Abort has priority over `start` and `stall`.
- `start` while not in IDLE is ignored; it is not queued.

## Timing
- **Reset values:** state IDLE; `vec_raddr`, `mat_raddr`, `accum_first`, `accum_last`, `ovalid`, `busy`, `done` all 0; pipeline cleared.
- **Start to first address:** with `start` at edge t, `busy` and the first address appear in cycle t+1.
- **First beat:** `ovalid` for the first beat appears in cycle t+1+RD_LAT.
- **Beat k:** issued at cycle c is presented with `ovalid` at c+RD_LAT. No reordering, no dropping.
- **Job length:** with no stalls, `busy` stays high for R·W+RD_LAT cycles. `done` coincides with the final `ovalid`/`accum_last`.
- **Zero-size job (W=0 or R=0):** `busy` high for exactly one cycle with `done`=1, `ovalid` never asserts.
- **`busy`:** high in RUN and DRAIN; low in IDLE. After `done`, the next start is accepted in the cycle `busy`=0.

## Test plan
- **Reset sweep:** hold `rst` 5 cycles mid-job (R=3, W=4) → all outputs 0 the cycle after reset; the job does not resume.
- **Basic, RD_LAT=1:** vec_start=3, W=4, mat_start=5, R=2, S=4, no stall → `vec_raddr` 3,4,5,6,3,4,5,6 and `mat_raddr` 5..12; `ovalid` 8 cycles; first on beats 0 and 4, last on beats 3 and 7; `busy` 9 cycles; `done` with beat 7.
- **Stride/wrap:** mat_start=510, W=2, R=2, S=10 → `mat_raddr` 510, 511, 8, 9 (wrap at 512); W=1, R=3 → `first=last=1` on every beat.
- **Stall:** W=3, R=1, `stall` high for 2 cycles after the first beat → addresses hold for 2 cycles; a 2-cycle bubble in `ovalid`; 3 valid beats total; `busy` 6 cycles (RD_LAT=1).
- **Abort:** R=4, W=4, abort at the 6th issued beat → no `ovalid` after that cycle, `busy` low next cycle, no `done`; an immediate new start runs cleanly.
- **Edge cases:**
  - Zero-size: W=0 → one `busy`+`done` cycle, no `ovalid`.
  - `start` pulsed during RUN → ignored, address sequence unchanged.
  - Repeat the basic test with RD_LAT=0 and RD_LAT=3.
